// File: rtl/sprite_frame_streamer.sv
// Raster frame walker that upscales a sprite sheet by SCALE and streams pixels over valid/ready.
// Optional CONTINUOUS_REFRESH_EN: restart the next frame right after pix_last instead of waiting for a sel change.
module sprite_frame_streamer #(
  parameter int H_RES      = 240,
  parameter int V_RES      = 240,
  parameter int SCALE      = 5,
  parameter int PIXEL_SIZE = 16,
  parameter int MEM_DEPTH  = 7000,
  parameter int NUM_STATES = 14,
  localparam int ADDR_W    = $clog2(MEM_DEPTH),
  localparam int STATE_W   = $clog2(NUM_STATES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STATE_W-1:0]    sel,
  input  logic                  cfg_we,
  input  logic [STATE_W-1:0]    cfg_state,
  input  logic [7:0]            cfg_row_lo,
  input  logic [7:0]            cfg_row_hi,
  input  logic [ADDR_W-1:0]     cfg_base,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [PIXEL_SIZE-1:0] mem_data,
  output logic [PIXEL_SIZE-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_first,
  output logic                  pix_last,
  output logic                  busy
);
  localparam int SRC_W   = H_RES / SCALE;
  localparam int SRC_H   = V_RES / SCALE;
  localparam int XW      = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW      = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int CW      = ($clog2(SRC_H + 1) > 8) ? $clog2(SRC_H + 1) : 8;
  localparam int NUM_ENT = 1 << STATE_W;

  // Stream handshake: a pixel transfers on every clk edge where pix_valid && pix_ready;
  // pix_valid never drops and the pixel never changes until that transfer happens.
  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;
  state_t state_q, state_d;

  logic [7:0]         tbl_lo   [NUM_ENT];
  logic [7:0]         tbl_hi   [NUM_ENT];
  logic [ADDR_W-1:0]  tbl_base [NUM_ENT];
  logic [STATE_W-1:0] last_sel;
  logic [7:0]         sh_lo, sh_hi, ent_lo, ent_hi;
  logic [ADDR_W-1:0]  sh_off, ent_base;

  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic [SW-1:0]      sx_q, sy_q;
  logic [ADDR_W-1:0]  src_x_q, row_base_q, addr_now;
  logic [CW-1:0]      src_y_q;
  logic               done_q, at_last, in_band;

  logic               req_v, req_first, req_last, rd_v, rd_first, rd_last;
  logic [PIXEL_SIZE-1:0] buf_data [3];
  logic               buf_first [3];
  logic               buf_last  [3];
  logic [1:0]         wr_ptr, rd_ptr, cnt_q;
  logic [2:0]         occ;
  logic               pop, room, last_pop, relatch, issue;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A write landing in the same cycle as the latch is forwarded into the shadow.
  always_comb begin
    ent_lo   = tbl_lo[sel];
    ent_hi   = tbl_hi[sel];
    ent_base = tbl_base[sel];
    if (cfg_we && cfg_state == sel) begin
      ent_lo   = cfg_row_lo;
      ent_hi   = cfg_row_hi;
      ent_base = cfg_base;
    end
  end

  // sh_off folds base - row_lo*SRC_W so the overlay address is row_base + src_x + sh_off.
  assign in_band  = (src_y_q >= CW'(sh_lo)) && (src_y_q < CW'(sh_hi));
  assign addr_now = row_base_q + src_x_q + (in_band ? sh_off : '0);
  assign at_last  = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));

  assign pix_valid = (cnt_q != 2'd0);
  assign pix_data  = buf_data[rd_ptr];
  assign pix_first = pix_valid & buf_first[rd_ptr];
  assign pix_last  = pix_valid & buf_last[rd_ptr];
  assign busy      = (state_q != IDLE);
  assign pop       = pix_valid && pix_ready;
  assign last_pop  = pop && buf_last[rd_ptr];

  // Output slot plus two skid entries cover the two reads still in flight when the sink stalls.
  assign occ  = 3'(cnt_q) + 3'(req_v) + 3'(rd_v) - 3'(pop);
  assign room = (occ < 3'd3);

  always_comb begin
    state_d = state_q;
    relatch = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel != last_sel) begin
          relatch = 1'b1;
          state_d = PRIME;
        end
      end
      PRIME: begin
        if (room) begin
          issue   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        issue = room && !done_q;
        if (last_pop) begin
`ifdef CONTINUOUS_REFRESH_EN
          relatch = 1'b1;
          state_d = PRIME;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_ENT; i++) begin
        tbl_lo[i]   <= '0;
        tbl_hi[i]   <= '0;
        tbl_base[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (cfg_we) begin
        tbl_lo[cfg_state]   <= cfg_row_lo;
        tbl_hi[cfg_state]   <= cfg_row_hi;
        tbl_base[cfg_state] <= cfg_base;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_sel   <= '1;
      sh_lo      <= '0;
      sh_hi      <= '0;
      sh_off     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      src_x_q    <= '0;
      src_y_q    <= '0;
      row_base_q <= '0;
      done_q     <= 1'b0;
      mem_addr   <= '0;
    end else if (relatch) begin
      last_sel   <= sel;
      sh_lo      <= ent_lo;
      sh_hi      <= ent_hi;
      sh_off     <= ent_base - ADDR_W'(ent_lo) * ADDR_W'(SRC_W);
      x_q        <= '0;
      y_q        <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      src_x_q    <= '0;
      src_y_q    <= '0;
      row_base_q <= '0;
      done_q     <= 1'b0;
    end else if (issue) begin
      mem_addr <= addr_now;
      done_q   <= at_last;
      if (x_q == XW'(H_RES - 1)) begin
        x_q     <= '0;
        sx_q    <= '0;
        src_x_q <= '0;
        y_q     <= (y_q == YW'(V_RES - 1)) ? '0 : y_q + 1'b1;
        if (sy_q == SW'(SCALE - 1)) begin
          sy_q       <= '0;
          src_y_q    <= src_y_q + 1'b1;
          row_base_q <= row_base_q + ADDR_W'(SRC_W);
        end else begin
          sy_q <= sy_q + 1'b1;
        end
      end else begin
        x_q <= x_q + 1'b1;
        if (sx_q == SW'(SCALE - 1)) begin
          sx_q    <= '0;
          src_x_q <= src_x_q + 1'b1;
        end else begin
          sx_q <= sx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_v     <= 1'b0;
      req_first <= 1'b0;
      req_last  <= 1'b0;
      rd_v      <= 1'b0;
      rd_first  <= 1'b0;
      rd_last   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        buf_data[i]  <= '0;
        buf_first[i] <= 1'b0;
        buf_last[i]  <= 1'b0;
      end
    end else begin
      req_v     <= issue;
      req_first <= issue && (x_q == '0) && (y_q == '0);
      req_last  <= issue && at_last;
      rd_v      <= req_v;
      rd_first  <= req_first;
      rd_last   <= req_last;
      if (rd_v) begin
        buf_data[wr_ptr]  <= mem_data;
        buf_first[wr_ptr] <= rd_first;
        buf_last[wr_ptr]  <= rd_last;
        wr_ptr            <= inc3(wr_ptr);
      end
      if (pop) rd_ptr <= inc3(rd_ptr);
      cnt_q <= cnt_q + 2'(rd_v) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_sprite_frame_streamer.sv
// Directed bench for sprite_frame_streamer on a reduced 40x30 frame (SCALE=5) with mem[a]=a.
module tb_sprite_frame_streamer;
  localparam int H  = 40;
  localparam int V  = 30;
  localparam int S  = 5;
  localparam int PX = 16;
  localparam int MD = 7000;
  localparam int NS = 14;
  localparam int AW = $clog2(MD);
  localparam int SW = $clog2(NS);
  localparam int SRC_W = H / S;
  localparam int N  = H * V;

  logic          clk, rst;
  logic [SW-1:0] sel, cfg_state;
  logic          cfg_we;
  logic [7:0]    cfg_row_lo, cfg_row_hi;
  logic [AW-1:0] cfg_base, mem_addr;
  logic [PX-1:0] mem_data, pix_data;
  logic          pix_valid, pix_ready, pix_first, pix_last, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [PX-1:0] frame_px [0:N-1];

  sprite_frame_streamer #(
    .H_RES(H), .V_RES(V), .SCALE(S), .PIXEL_SIZE(PX), .MEM_DEPTH(MD), .NUM_STATES(NS)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .cfg_we(cfg_we), .cfg_state(cfg_state),
    .cfg_row_lo(cfg_row_lo), .cfg_row_hi(cfg_row_hi), .cfg_base(cfg_base),
    .mem_addr(mem_addr), .mem_data(mem_data), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_first(pix_first), .pix_last(pix_last), .busy(busy)
  );

  // Clock / reset / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= PX'(mem_addr);

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic int exp_pix(input int x, input int y, input int lo, input int hi, input int base);
    int sxp, syp;
    sxp = x / S;
    syp = y / S;
    if (syp >= lo && syp < hi) return (base + (syp - lo) * SRC_W + sxp) % (1 << AW);
    return syp * SRC_W + sxp;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int st, input int lo, input int hi, input int base);
    cfg_we     = 1'b1;
    cfg_state  = SW'(st);
    cfg_row_lo = 8'(lo);
    cfg_row_hi = 8'(hi);
    cfg_base   = AW'(base);
  endtask

  // Driver + scoreboard for one frame; called at a negedge, returns at the negedge after pix_last.
  task automatic run_frame(input bit rnd, input int mode, input int lo, input int hi,
                           input int base, input string tag);
    int beats, cyc, bad_data, bad_first, bad_last, bad_hold, e;
    bit done, stall;
    logic [PX-1:0] hold_d;
    logic hold_f, hold_l;
    beats = 0; cyc = 0; bad_data = 0; bad_first = 0; bad_last = 0; bad_hold = 0;
    done = 1'b0; stall = 1'b0; hold_d = '0; hold_f = 1'b0; hold_l = 1'b0;
    while (!done && cyc < 4 * N + 100) begin
      cfg_we = 1'b0;
      if (stall && !(pix_valid === 1'b1 && pix_data === hold_d &&
                     pix_first === hold_f && pix_last === hold_l)) bad_hold++;
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall  = (pix_valid === 1'b1) && !pix_ready;
      hold_d = pix_data;
      hold_f = pix_first;
      hold_l = pix_last;
      if (pix_valid === 1'b1 && pix_ready) begin
        e = exp_pix(beats % H, beats / H, lo, hi, base);
        if (pix_data !== PX'(e)) bad_data++;
        if (pix_first !== (beats == 0)) bad_first++;
        if (pix_last !== (beats == N - 1)) bad_last++;
        if (beats < N) frame_px[beats] = pix_data;
        beats++;
        if (pix_last === 1'b1) done = 1'b1;
        if (mode == 1 && beats == 100) sel = SW'(1);
        if (mode == 1 && beats == 130) cfg_write(0, 0, 6, 3000);
        if (mode == 1 && beats == 150) sel = SW'(2);
      end
      @(negedge clk);
      cyc++;
    end
    pix_ready = 1'b1;
    cfg_we = 1'b0;
    check({tag, "_beats"}, 32'(beats), 32'(N));
    check({tag, "_data_errs"}, 32'(bad_data), 0);
    check({tag, "_first_errs"}, 32'(bad_first), 0);
    check({tag, "_last_errs"}, 32'(bad_last), 0);
    check({tag, "_hold_errs"}, 32'(bad_hold), 0);
  endtask

  task automatic check_idle(input string tag);
    repeat (5) @(negedge clk);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_valid"}, 32'(pix_valid), 0);
  endtask

  initial begin
    int k, cyc, gap;
    rst = 1'b1; sel = '0; pix_ready = 1'b1;
    cfg_we = 1'b0; cfg_state = '0; cfg_row_lo = '0; cfg_row_hi = '0; cfg_base = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(pix_valid), 0);
    check("rst_first", 32'(pix_first), 0);
    check("rst_last", 32'(pix_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_data", 32'(pix_data), 0);
    rst = 1'b0;

    // Scenario 1: first frame after reset, latency of 3 cycles from leaving IDLE
    @(negedge clk);
    check("lat_busy", 32'(busy), 1);
    check("lat_valid1", 32'(pix_valid), 0);
    @(negedge clk);
    check("lat_valid2", 32'(pix_valid), 0);
    @(negedge clk);
    check("lat_valid3", 32'(pix_valid), 0);
    @(negedge clk);
    check("lat_valid4", 32'(pix_valid), 1);
    check("lat_first", 32'(pix_first), 1);
`ifdef CONTINUOUS_REFRESH_EN
    // Scenario 6: back-to-back frames with sel held
    run_frame(1'b0, 0, 0, 0, 0, "c1");
    for (int f = 0; f < 2; f++) begin
      gap = 0;
      while (pix_valid !== 1'b1 && gap < 10) begin
        @(negedge clk);
        gap++;
      end
      check("c_refill_ok", 32'(gap <= 3), 1);
      run_frame(1'b0, 0, 0, 0, 0, "cn");
    end
`else
    run_frame(1'b0, 0, 0, 0, 0, "s1");
    check("s1_end_busy", 32'(busy), 0);
    check("s1_end_valid", 32'(pix_valid), 0);
    check_idle("s1_idle");
    check("s1_p_0_0", 32'(frame_px[0]), 0);
    check("s1_p_5_0", 32'(frame_px[5]), 1);
    check("s1_p_0_5", 32'(frame_px[5 * H]), 8);
    check("s1_p_39_29", 32'(frame_px[29 * H + 39]), 47);

    // Scenario 2: overlay written in the same cycle sel switches to it
    cfg_write(1, 2, 4, 1000);
    sel = SW'(1);
    @(negedge clk);
    cfg_we = 1'b0;
    run_frame(1'b0, 0, 2, 4, 1000, "s2");
    check("s2_p_0_10", 32'(frame_px[10 * H]), 1000);
    check("s2_p_39_19", 32'(frame_px[19 * H + 39]), 1015);
    check("s2_p_0_20", 32'(frame_px[20 * H]), 32);
    check("s2_p_0_9", 32'(frame_px[9 * H]), 8);

    // Scenario 3: random back-pressure on an empty-table state
    sel = SW'(3);
    run_frame(1'b1, 0, 0, 0, 0, "s3");
    check("s3_p_39_29", 32'(frame_px[29 * H + 39]), 47);

    // Scenario 4: sel changes and active-state write mid-frame
    cfg_write(2, 0, 1, 2000);
    @(negedge clk);
    cfg_we = 1'b0;
    @(negedge clk);
    check("s4_cfg_no_start", 32'(busy), 0);
    sel = SW'(0);
    run_frame(1'b0, 1, 0, 0, 0, "s4a");
    run_frame(1'b0, 0, 0, 1, 2000, "s4b");
    check("s4b_p_0_0", 32'(frame_px[0]), 2000);
    check("s4b_p_39_4", 32'(frame_px[4 * H + 39]), 2007);
    check("s4b_p_0_5", 32'(frame_px[5 * H]), 8);
    check_idle("s4_one_extra");

    // Scenario 5: reset pulse mid-frame
    sel = SW'(1);
    k = 0;
    cyc = 0;
    while (k < 600 && cyc < 3000) begin
      if (pix_valid === 1'b1 && pix_ready) k++;
      @(negedge clk);
      cyc++;
    end
    check("s5_reach", 32'(k), 600);
    rst = 1'b1;
    @(negedge clk);
    check("s5_rst_valid", 32'(pix_valid), 0);
    check("s5_rst_busy", 32'(busy), 0);
    check("s5_rst_first", 32'(pix_first), 0);
    check("s5_rst_addr", 32'(mem_addr), 0);
    rst = 1'b0;
    run_frame(1'b0, 0, 0, 0, 0, "s5");
    check("s5_cleared_p_0_10", 32'(frame_px[10 * H]), 16);
    check_idle("s5_idle");
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sprite_frame_streamer.md
Name: sprite_frame_streamer

Overview:
Parametrised pixel-stream generator for the SPI LCD path. Walks an H_RES x V_RES frame in raster order and upscales a low-resolution sprite sheet by an integer SCALE factor. For each display state it substitutes one programmable band of source rows with an overlay sprite. Pixels go to the display controller over a valid/ready stream, so the controller's data-clock pacing no longer has to match the frame walker.

Parameters:
H_RES, 240, output frame width in pixels
V_RES, 240, output frame height in pixels
SCALE, 5, integer upscale factor; H_RES and V_RES must be multiples of SCALE
PIXEL_SIZE, 16, bits per pixel (RGB565)
MEM_DEPTH, 7000, sprite-memory words; ADDR_W = clog2(MEM_DEPTH)
NUM_STATES, 14, number of display states; STATE_W = clog2(NUM_STATES)

Ports:
clk  in  1  single system clock
rst  in  1  synchronous reset, active-high
sel  in  STATE_W  requested display state
cfg_we  in  1  overlay-table write strobe
cfg_state  in  STATE_W  table entry written when cfg_we=1
cfg_row_lo  in  8  first overlaid source row (inclusive)
cfg_row_hi  in  8  end of the overlaid band (exclusive)
cfg_base  in  ADDR_W  sprite address of overlay row 0, column 0
mem_addr  out  ADDR_W  sprite-memory read address
mem_data  in  PIXEL_SIZE  sprite word; valid exactly 1 cycle after mem_addr
pix_data  out  PIXEL_SIZE  output pixel
pix_valid  out  1  pixel available
pix_ready  in  1  sink accepts pixel
pix_first  out  1  qualifies pixel (0,0) of a frame
pix_last  out  1  qualifies pixel (H_RES-1,V_RES-1)
busy  out  1  frame in progress

Behaviour:
- Reset values: pix_valid=0, pix_first=0, pix_last=0, busy=0, mem_addr=0, pix_data=0. Every table entry resets to row_lo=row_hi=0 and base=0, which means no overlay.
- Source width: SRC_W = H_RES/SCALE.
- Scaling counters:
  - x and y raster counters, plus sub-counters sx and sy that run 0..SCALE-1.
  - src_x increments when sx wraps; src_y increments when x and sy both wrap.
  - No dividers; use a running row base (src_y*SRC_W) that is updated by addition.
- Address rule:
  - If row_lo <= src_y < row_hi for the active state: addr = base + (src_y-row_lo)*SRC_W + src_x.
  - Otherwise: addr = src_y*SRC_W + src_x.
  - All arithmetic is ADDR_W wide and modulo 2^ADDR_W; no range check.
  - An entry with row_lo >= row_hi never matches.
- FSM: IDLE -> PRIME -> STREAM -> IDLE.
  - IDLE: busy=0.
    - Leave IDLE when sel differs from last_sel, or on the first cycle after reset (last_sel resets to all-ones, forcing a first frame).
    - On leaving IDLE: latch active_state=sel and last_sel=sel; capture that state's table entry into shadow registers.
  - PRIME: issue address (0,0); busy=1.
  - STREAM:
    - Issue one address per cycle while the output buffer has room.
    - After the address for (H_RES-1,V_RES-1) is issued, stop issuing and return to IDLE once that pixel's handshake completes.
- Output buffer:
  - Two-entry skid buffer after the memory stage.
  - A new address is issued only if the buffer will have a free slot when its data returns.
  - No pixel is dropped or duplicated.
  - pix_data, pix_first and pix_last are held stable while pix_valid=1 and pix_ready=0.
  - With pix_ready held at 1, first pix_valid occurs 3 cycles after leaving IDLE, followed by 1 pixel per cycle.
- Frame count: exactly H_RES*V_RES handshakes per frame; pix_first only on handshake 1, pix_last only on handshake H_RES*V_RES.
- sel changes:
  - A sel change mid-frame has no effect on the current frame.
  - It is acted on in IDLE after the frame ends.
  - Multiple changes during one frame produce one new frame, rendered with sel as sampled in IDLE.
- cfg writes:
  - A cfg_we write takes effect on the next frame.
  - A write to the active state mid-frame does not alter the current frame, because the frame reads only the shadow registers.
  - cfg_we in the same cycle as the IDLE latch for the same state: the shadow captures the new value.
- Reset mid-frame: synchronous, so all outputs return to reset values the cycle after rst is sampled high. The table is cleared and a fresh frame starts after rst deasserts.

Optional Feature:
CONTINUOUS_REFRESH_EN
- Defined: after pix_last completes, the FSM returns to PRIME on the next cycle regardless of sel, re-latching sel and the table entry first. Frames repeat back-to-back with no gap beyond pipeline refill.
- Undefined: the FSM waits in IDLE until sel differs from last_sel; the display keeps its last frame.

Test Plan:
1. Defaults (H_RES=V_RES=240, SCALE=5), mem[a]=a, empty table, pix_ready=1, release reset -> pixels (0,0)=0, (5,0)=1, (0,5)=48, (239,239)=2303; exactly 57600 beats; pix_first on beat 1, pix_last on beat 57600; then IDLE with busy=0.
2. Write state 1 as row_lo=24, row_hi=28, base=2305; set sel=1 -> pixel (0,120)=2305, (239,139)=2496, (0,140)=1344, (0,119)=1104.
3. pix_ready random at 50% duty -> pixel sequence identical to scenario 1; pix_data stable on every stalled cycle; 57600 beats.
4. sel 0->1->2 between pixels 1000 and 2000 -> current frame finishes unchanged with state-0 data; exactly one extra frame follows, rendered with state 2.
5. rst pulsed for 1 cycle at pixel 30000 -> pix_valid=0 and busy=0 the next cycle; table cleared; new frame starts with pix_first on pixel (0,0).
6. With CONTINUOUS_REFRESH_EN, sel held constant -> three consecutive frames of 57600 beats each, with pix_first immediately after each pix_last plus pipeline refill (≤3 cycles).
